// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   state_t  - FSM state encoding (S_IDLE, S_RUN, S_DONE), 2 bits.
//   cnt_w()  - bit-counter width for a given operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_fullsub.sv
// fullsub: 1-bit full subtractor built from gate primitives.
//   diff  out  a ^ b ^ b_in
//   b_out out  (~a & b) | (~(a ^ b) & b_in)
//   a     in   minuend bit
//   b     in   subtrahend bit
//   b_in  in   borrow in
module fullsub (
  output logic diff,
  output logic b_out,
  input  logic a,
  input  logic b,
  input  logic b_in
);

  logic a_x_b;
  logic a_n;
  logic axb_n;
  logic gen;
  logic prop;

  xor u_x1 (a_x_b, a, b);
  xor u_x2 (diff, a_x_b, b_in);
  not u_n1 (a_n, a);
  and u_a1 (gen, a_n, b);
  not u_n2 (axb_n, a_x_b);
  and u_a2 (prop, axb_n, b_in);
  or  u_o1 (b_out, gen, prop);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = a - b - b_in, LSB first.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request strobe, honoured only in IDLE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   b_in   in   borrow in, captured on the accepting edge
//   busy   out  high while the WIDTH bits are being processed
//   done   out  one-cycle pulse when diff/b_out hold the new result
//   diff   out  (a - b - b_in) mod 2^WIDTH
//   b_out  out  1 when a < b + b_in (unsigned)
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic            br;
  logic            cell_d;
  logic            cell_br;

  // The single arithmetic cell always works on the current LSBs.
  fullsub u_cell (
    .diff  (cell_d),
    .b_out (cell_br),
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .b_in  (br)
  );

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values; blocking here would make order matter.
  // NOTE: every register, outputs included, has a reset value so an abort
  // mid-RUN leaves no stale partial result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: the default arm covers the unused encoding, so no state or
      // output is left unassigned on any path.
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          diff <= {cell_d, diff[WIDTH-1:1]};
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          br   <= cell_br;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            b_out <= cell_br;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
